// File: rtl/riscv_pmp_memgate.sv
// Request buffer in front of the PMP checker: presents the oldest request for a
// one-cycle check, then issues it to the BIU or retires it as an access fault.
module riscv_pmp_memgate #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned PLEN  = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_i,
   input  logic [PLEN-1:0] adr_i,
   input  logic [2:0]      size_i,
   input  logic            we_i,
   input  logic            instruction_i,
   input  logic [XLEN-1:0] d_i,
   output logic            ready_o,
   input  logic            flush_i,
   output logic            chk_req_o,
   output logic [PLEN-1:0] chk_adr_o,
   output logic [2:0]      chk_size_o,
   output logic            chk_we_o,
   output logic            chk_instruction_o,
   input  logic            chk_exception_i,
   output logic            biu_req_o,
   output logic [PLEN-1:0] biu_adr_o,
   output logic [2:0]      biu_size_o,
   output logic            biu_we_o,
   output logic [XLEN-1:0] biu_d_o,
   input  logic            biu_ack_i,
   output logic            fault_o,
   output logic [PLEN-1:0] fault_adr_o,
   output logic            fault_we_o,
   output logic            fault_instruction_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic [PLEN-1:0] adr;
      logic [2:0]      size;
      logic            we;
      logic            instruction;
      logic [XLEN-1:0] d;
   } entry_t;

   typedef enum logic [1:0] {ST_EMPTY, ST_CHECK, ST_ISSUE, ST_FAULT} state_t;

   state_t          state_q;
   entry_t          mem_q [DEPTH];
   entry_t          head;
   logic [PW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            hold_q, hold_d;
   logic            ready_q, ready_d;
   logic            verdict_q;
   logic [PLEN-1:0] fault_adr_q;
   logic            fault_we_q, fault_instr_q;
   logic            push, pop, flush_keep, flush_all, fault_c;

   assign head       = mem_q[rptr_q];
   assign push       = req_i & ready_q & ~flush_i;
   assign pop        = (state_q == ST_ISSUE & biu_ack_i) | (state_q == ST_FAULT);
   assign flush_keep = flush_i & (state_q == ST_ISSUE);
   assign flush_all  = flush_i & ~flush_keep;
   assign fault_c    = (state_q == ST_FAULT) & verdict_q & ~flush_i;

   // Pointer/occupancy update; a flush during ISSUE keeps only the outstanding head
   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      hold_d  = hold_q;
      if (flush_all) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
         hold_d  = 1'b0;
      end else if (flush_keep) begin
         wptr_d = rptr_q + PW'(1);
         if (biu_ack_i) begin
            rptr_d  = rptr_q + PW'(1);
            count_d = '0;
            hold_d  = 1'b0;
         end else begin
            count_d = CW'(1);
            hold_d  = 1'b1;
         end
      end else begin
         if (push) wptr_d = wptr_q + PW'(1);
         if (pop) begin
            rptr_d = rptr_q + PW'(1);
            hold_d = 1'b0;
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   assign ready_d = (count_d != CW'(DEPTH)) & ~hold_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_EMPTY;
         rptr_q        <= '0;
         wptr_q        <= '0;
         count_q       <= '0;
         hold_q        <= 1'b0;
         ready_q       <= 1'b0;
         verdict_q     <= 1'b0;
         fault_adr_q   <= '0;
         fault_we_q    <= 1'b0;
         fault_instr_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         hold_q  <= hold_d;
         ready_q <= ready_d;
         if (push) mem_q[wptr_q] <= '{adr: adr_i, size: size_i, we: we_i,
                                      instruction: instruction_i, d: d_i};
         if (fault_c) begin
            fault_adr_q   <= head.adr;
            fault_we_q    <= head.we;
            fault_instr_q <= head.instruction;
         end
         case (state_q)
            ST_EMPTY: if (!flush_i && count_q != '0) state_q <= ST_CHECK;
            ST_CHECK: begin
               verdict_q <= chk_exception_i;
               if (flush_i)              state_q <= ST_EMPTY;
               else if (chk_exception_i) state_q <= ST_FAULT;
               else                      state_q <= ST_ISSUE;
            end
            ST_ISSUE: if (biu_ack_i) state_q <= (count_d != '0) ? ST_CHECK : ST_EMPTY;
            ST_FAULT: state_q <= (!flush_i && count_d != '0) ? ST_CHECK : ST_EMPTY;
            default:  state_q <= ST_EMPTY;
         endcase
      end
   end

   assign ready_o             = ready_q;
   assign chk_req_o           = (state_q == ST_CHECK);
   assign chk_adr_o           = head.adr;
   assign chk_size_o          = head.size;
   assign chk_we_o            = head.we;
   assign chk_instruction_o   = head.instruction;
   assign biu_req_o           = (state_q == ST_ISSUE);
   assign biu_adr_o           = head.adr;
   assign biu_size_o          = head.size;
   assign biu_we_o            = head.we;
   assign biu_d_o             = head.d;
   // Fault info is visible with the pulse and held afterwards
   assign fault_o             = fault_c;
   assign fault_adr_o         = fault_c ? head.adr : fault_adr_q;
   assign fault_we_o          = fault_c ? head.we : fault_we_q;
   assign fault_instruction_o = fault_c ? head.instruction : fault_instr_q;

endmodule

// File: tb/tb_riscv_pmp_memgate.sv
// Directed bench for riscv_pmp_memgate: a queue-based request model checked every
// cycle, plus literal expectations at the key latency points.
module tb_riscv_pmp_memgate;

   localparam int unsigned DEPTH = 2;

   logic        clk, rst_i, req_i, we_i, instruction_i, flush_i;
   logic [63:0] adr_i, d_i;
   logic [2:0]  size_i;
   logic        ready_o, chk_req_o, chk_we_o, chk_instruction_o, chk_exception_i;
   logic [63:0] chk_adr_o, biu_adr_o, biu_d_o, fault_adr_o;
   logic [2:0]  chk_size_o, biu_size_o;
   logic        biu_req_o, biu_we_o, biu_ack_i, fault_o, fault_we_o, fault_instruction_o;

   riscv_pmp_memgate #(.XLEN(64), .PLEN(64), .DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .adr_i(adr_i), .size_i(size_i),
      .we_i(we_i), .instruction_i(instruction_i), .d_i(d_i), .ready_o(ready_o),
      .flush_i(flush_i), .chk_req_o(chk_req_o), .chk_adr_o(chk_adr_o),
      .chk_size_o(chk_size_o), .chk_we_o(chk_we_o), .chk_instruction_o(chk_instruction_o),
      .chk_exception_i(chk_exception_i), .biu_req_o(biu_req_o), .biu_adr_o(biu_adr_o),
      .biu_size_o(biu_size_o), .biu_we_o(biu_we_o), .biu_d_o(biu_d_o), .biu_ack_i(biu_ack_i),
      .fault_o(fault_o), .fault_adr_o(fault_adr_o), .fault_we_o(fault_we_o),
      .fault_instruction_o(fault_instruction_o));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Checker stand-in: everything below 0x1000 is protected
   function automatic bit deny(input logic [63:0] a);
      return a < 64'h1000;
   endfunction
   assign chk_exception_i = deny(chk_adr_o);

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [63:0] adr;
      logic [2:0]  size;
      logic        we;
      logic        ins;
      logic [63:0] d;
   } mreq_t;

   mreq_t       q[$];
   int          m_phase = 0;   // 0 waiting, 1 being checked, 2 at the BIU, 3 faulting
   int          iss_age = 0;
   int          ack_delay = 0;
   bit          hold = 0, m_ready = 0, m_valid = 0, m_zero = 0;
   logic [63:0] m_fadr = '0;
   logic        m_fwe = 0, m_fins = 0;
   logic        ack_r = 0;

   assign biu_ack_i = ack_r;

   always @(posedge clk) begin
      bit    pushed, settle;
      mreq_t n;
      if (rst_i) begin
         q.delete();
         m_phase = 0; iss_age = 0; hold = 0; m_ready = 0;
         m_fadr = '0; m_fwe = 0; m_fins = 0;
         m_valid = 1; m_zero = 1;
      end else begin
         m_zero = 0;
         settle = 0;
         pushed = req_i && m_ready && !flush_i;
         n = '{adr: adr_i, size: size_i, we: we_i, ins: instruction_i, d: d_i};
         case (m_phase)
            0: if (flush_i) q.delete(); else if (q.size() != 0) m_phase = 1;
            1: if (flush_i) begin q.delete(); m_phase = 0; end
               else begin m_phase = deny(q[0].adr) ? 3 : 2; iss_age = 0; end
            2: begin
               if (flush_i) begin
                  while (q.size() > 1) q.delete(q.size() - 1);
                  hold = 1;
               end
               if (biu_ack_i) begin q.delete(0); hold = 0; settle = 1; end
               else iss_age++;
            end
            default: begin
               if (flush_i) begin q.delete(); m_phase = 0; end
               else begin
                  m_fadr = q[0].adr; m_fwe = q[0].we; m_fins = q[0].ins;
                  q.delete(0); settle = 1;
               end
            end
         endcase
         if (pushed) q.push_back(n);
         if (settle) m_phase = (q.size() != 0) ? 1 : 0;
         m_ready = (q.size() < DEPTH) && !hold;
      end
   end

   always @(posedge clk) begin
      #1;
      ack_r = (m_phase == 2) && (iss_age >= ack_delay);
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      logic exp_fault;
      if (m_valid) begin
         exp_fault = (m_phase == 3) && !flush_i;
         check("ready_o", ready_o, m_ready);
         check("chk_req_o", chk_req_o, m_phase == 1);
         check("biu_req_o", biu_req_o, m_phase == 2);
         check("fault_o", fault_o, exp_fault);
         check("fault_adr_o", fault_adr_o, exp_fault ? q[0].adr : m_fadr);
         check("fault_we_o", fault_we_o, exp_fault ? q[0].we : m_fwe);
         check("fault_instruction_o", fault_instruction_o, exp_fault ? q[0].ins : m_fins);
         if (q.size() != 0) begin
            check("chk_adr_o", chk_adr_o, q[0].adr);
            check("chk_size_o", chk_size_o, q[0].size);
            check("chk_we_o", chk_we_o, q[0].we);
            check("chk_instruction_o", chk_instruction_o, q[0].ins);
            check("biu_adr_o", biu_adr_o, q[0].adr);
            check("biu_size_o", biu_size_o, q[0].size);
            check("biu_we_o", biu_we_o, q[0].we);
            check("biu_d_o", biu_d_o, q[0].d);
         end
         if (m_zero) begin
            check("rst_chk_adr", chk_adr_o, 64'h0);
            check("rst_biu_adr", biu_adr_o, 64'h0);
            check("rst_biu_d", biu_d_o, 64'h0);
            check("rst_sizes", {chk_size_o, biu_size_o}, 64'h0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] a, input logic [2:0] s, input logic w,
                       input logic ins, input logic [63:0] dd);
      int n = 0;
      bit acc = 0;
      req_i = 1'b1; adr_i = a; size_i = s; we_i = w; instruction_i = ins; d_i = dd;
      do begin
         acc = ready_o;
         tick();
         n++;
      end while (!acc && n < 60);
      req_i = 1'b0;
      if (!acc) check("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_phase(input int p);
      int n = 0;
      while (m_phase != p && n < 60) begin tick(); n++; end
      if (m_phase != p) check("wait_phase_timeout", 64'(m_phase), 64'(p));
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q.size() != 0 || m_phase != 0) && n < 200) begin tick(); n++; end
      if (q.size() != 0 || m_phase != 0) check("wait_idle_timeout", 64'(q.size()), 64'd0);
   endtask

   initial begin
      rst_i = 1'b1; req_i = 1'b0; flush_i = 1'b0; we_i = 1'b0; instruction_i = 1'b0;
      adr_i = '0; d_i = '0; size_i = '0;
      tick(); tick();
      check("reset_ready", ready_o, 64'd0);
      check("reset_biu_req", biu_req_o, 64'd0);
      rst_i = 1'b0;
      tick();
      check("ready_after_reset", ready_o, 64'd1);

      // Single allowed load: check at N+1, issue at N+2, drained at N+3
      ack_delay = 0;
      send(64'h8000_1000, 3'd2, 1'b0, 1'b0, 64'h0);
      check("load_n0_chk_req", chk_req_o, 64'd0);
      tick();
      check("load_n1_chk_req", chk_req_o, 64'd1);
      tick();
      check("load_n2_biu_req", biu_req_o, 64'd1);
      check("load_n2_biu_adr", biu_adr_o, 64'h8000_1000);
      tick();
      check("load_n3_biu_req", biu_req_o, 64'd0);
      check("load_n3_ready", ready_o, 64'd1);

      // Faulting store to 0x40
      send(64'h40, 3'd3, 1'b1, 1'b0, 64'hDEAD_BEEF);
      tick(); tick();
      check("store_fault_pulse", fault_o, 64'd1);
      check("store_fault_adr", fault_adr_o, 64'h40);
      check("store_fault_we", fault_we_o, 64'd1);
      check("store_no_biu", biu_req_o, 64'd0);
      tick();
      check("store_fault_end", fault_o, 64'd0);
      check("store_fault_adr_held", fault_adr_o, 64'h40);

      // Fill with slow BIU
      ack_delay = 5;
      send(64'h8000_2000, 3'd3, 1'b1, 1'b0, 64'h1111);
      send(64'h8000_2008, 3'd3, 1'b1, 1'b0, 64'h2222);
      check("fill_ready_low", ready_o, 64'd0);
      send(64'h8000_2010, 3'd1, 1'b0, 1'b0, 64'h0);
      wait_idle();

      // Flush while the head is at the BIU
      ack_delay = 3;
      send(64'h8000_5000, 3'd2, 1'b0, 1'b0, 64'h0);
      send(64'h8000_5008, 3'd2, 1'b0, 1'b0, 64'h0);
      wait_phase(2);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("flush_issue_ready_low", ready_o, 64'd0);
      check("flush_issue_head_kept", biu_adr_o, 64'h8000_5000);
      wait_idle();
      check("flush_issue_ready_back", ready_o, 64'd1);

      // Flush in the fault cycle, with a push that must be ignored
      ack_delay = 0;
      send(64'h80, 3'd3, 1'b1, 1'b0, 64'h0);
      wait_phase(3);
      flush_i = 1'b1; req_i = 1'b1; adr_i = 64'h8000_9000;
      #1;
      check("flush_fault_pulse", fault_o, 64'd0);
      check("flush_fault_adr_kept", fault_adr_o, 64'h40);
      tick();
      flush_i = 1'b0; req_i = 1'b0;
      check("flush_fault_empty", chk_req_o | biu_req_o, 64'd0);
      tick();
      check("flush_push_ignored", chk_req_o, 64'd0);

      // Reset during ISSUE, then a fresh request
      ack_delay = 10;
      send(64'h8000_3000, 3'd2, 1'b0, 1'b0, 64'h0);
      wait_phase(2);
      rst_i = 1'b1;
      tick();
      check("rst_mid_biu_req", biu_req_o, 64'd0);
      check("rst_mid_ready", ready_o, 64'd0);
      check("rst_mid_biu_adr", biu_adr_o, 64'h0);
      rst_i = 1'b0;
      ack_delay = 0;
      tick();
      send(64'h8000_4000, 3'd2, 1'b0, 1'b0, 64'h0);
      tick(); tick();
      check("post_rst_biu_req", biu_req_o, 64'd1);
      check("post_rst_biu_adr", biu_adr_o, 64'h8000_4000);
      wait_idle();

      // Back-to-back: illegal size, fetch, fetch fault
      send(64'h8000_6000, 3'd7, 1'b0, 1'b1, 64'h0);
      send(64'h8000_6004, 3'd2, 1'b0, 1'b1, 64'h0);
      send(64'h100, 3'd2, 1'b0, 1'b1, 64'h0);
      wait_idle();
      check("fetch_fault_adr", fault_adr_o, 64'h100);
      check("fetch_fault_ins", fault_instruction_o, 64'd1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
